divider_normalizer: RTL and testbench

- Pre-division normalization stage of the SRT divider datapath, directly upstream of the divider core and the remainder de-normalizing right shifter.
- Left-shifts the divisor M one bit per cycle until its top magnitude bit (bit WIDTH-2) is 1. The dividend pair {A,Q} shifts in lock-step.
- Reports the shift count on a 3-bit bus. The downstream right shifter consumes this count as its shift_pos to restore the remainder.
- Flags division by zero instead of normalizing.

---
 rtl/divider_normalizer_pkg.sv | 19 +
 rtl/norm_shift_reg.sv | 28 ++
 rtl/divider_normalizer.sv | 113 +++++++++++
 tb/tb_divider_normalizer.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/divider_normalizer_pkg.sv
// Shared divider definitions: FSM encoding and width defaults used by the
// normalizer and the downstream remainder right shifter.
package divider_normalizer_pkg;

  // Normalizer FSM encoding.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Width of A and M, including the sign/guard bit at WIDTH-1.
  localparam int WIDTH_DEF     = 17;
  // Width of the shift count bus; matches the right shifter's shift_pos.
  localparam int CNT_W_DEF     = 3;
  // Largest shift count representable on the count bus.
  localparam int MAX_SHIFT_DEF = 2**CNT_W_DEF - 1;

endpackage

// File: rtl/norm_shift_reg.sv
// Loadable left-shift register with serial input (LSB) and serial output (MSB).
module norm_shift_reg #(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         shift,
  input  logic         serial_in,
  output logic [W-1:0] q,
  output logic         serial_out
);

  // Load has priority over shift; otherwise the contents are held.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (shift) begin
      q <= {q[W-2:0], serial_in};
    end
  end

  assign serial_out = q[W-1];

endmodule

// File: rtl/divider_normalizer.sv
// Pre-division normalizer: shifts divisor M left until bit WIDTH-2 is set
// (or MAX_SHIFT is reached), shifting {A,Q} in lock-step, and reports the
// shift count. A zero divisor skips normalization and raises div_by_zero.
module divider_normalizer
  import divider_normalizer_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int CNT_W     = CNT_W_DEF,
  parameter int MAX_SHIFT = MAX_SHIFT_DEF
) (
  input  logic               clk,
  input  logic               rst_b,
  input  logic               start,
  input  logic [WIDTH-2:0]   divisor_in,
  input  logic [WIDTH-2:0]   dividend_in,
  output logic               busy,
  output logic               done,
  output logic               div_by_zero,
  output logic [WIDTH-1:0]   m_out,
  output logic [WIDTH-1:0]   a_out,
  output logic [WIDTH-2:0]   q_out,
  output logic [CNT_W-1:0]   shift_cnt,
  output logic [1:0]         state_dbg
);

  localparam int AQ_W = 2*WIDTH - 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_SHIFT);

  state_t            state, next_state;
  logic              load, shift;
  logic [CNT_W-1:0]  cnt;
  logic              dbz;
  logic [WIDTH-1:0]  m_q;
  logic [AQ_W-1:0]   aq_q;
  logic              m_serial_out, aq_serial_out;
  logic              unused_serial;

  // State register.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) state <= ST_IDLE;
    else        state <= next_state;
  end

  // Next-state and datapath control. start is only honoured in IDLE, so a
  // start during SHIFT or in the DONE cycle has no effect.
  always_comb begin
    next_state = state;
    load       = 1'b0;
    shift      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          load       = 1'b1;
          next_state = (divisor_in == '0) ? ST_DONE : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (m_q[WIDTH-2] || (cnt == CNT_MAX)) next_state = ST_DONE;
        else                                  shift      = 1'b1;
      end
      ST_DONE:  next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  // Shift counter and divide-by-zero flag, both captured at load.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      cnt <= '0;
      dbz <= 1'b0;
    end else if (load) begin
      cnt <= '0;
      dbz <= (divisor_in == '0);
    end else if (shift) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  norm_shift_reg #(.W(WIDTH)) u_m_reg (
    .clk        (clk),
    .rst_b      (rst_b),
    .load       (load),
    .load_val   ({1'b0, divisor_in}),
    .shift      (shift),
    .serial_in  (1'b0),
    .q          (m_q),
    .serial_out (m_serial_out)
  );

  norm_shift_reg #(.W(AQ_W)) u_aq_reg (
    .clk        (clk),
    .rst_b      (rst_b),
    .load       (load),
    .load_val   ({{WIDTH{1'b0}}, dividend_in}),
    .shift      (shift),
    .serial_in  (1'b0),
    .q          (aq_q),
    .serial_out (aq_serial_out)
  );

  // Bits shifted out of the top are discarded.
  assign unused_serial = m_serial_out ^ aq_serial_out;

  assign busy        = (state != ST_IDLE);
  assign done        = (state == ST_DONE);
  assign div_by_zero = dbz;
  assign m_out       = m_q;
  assign a_out       = aq_q[AQ_W-1:WIDTH-1];
  assign q_out       = aq_q[WIDTH-2:0];
  assign shift_cnt   = cnt;
  assign state_dbg   = state;

endmodule

// File: tb/tb_divider_normalizer.sv
// Directed and randomized bench for divider_normalizer with a reference model
// based on the divisor's leading-one position.
module tb_divider_normalizer;

  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic        start = 1'b0;
  logic [15:0] divisor_in = '0;
  logic [15:0] dividend_in = '0;
  logic        busy, done, div_by_zero;
  logic [16:0] m_out, a_out;
  logic [15:0] q_out;
  logic [2:0]  shift_cnt;
  logic [1:0]  state_dbg;

  int tests = 0;
  int fails = 0;

  divider_normalizer dut (
    .clk         (clk),
    .rst_b       (rst_b),
    .start       (start),
    .divisor_in  (divisor_in),
    .dividend_in (dividend_in),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .m_out       (m_out),
    .a_out       (a_out),
    .q_out       (q_out),
    .shift_cnt   (shift_cnt),
    .state_dbg   (state_dbg)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Checks every output against the reset values.
  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_dbz"},  64'(div_by_zero), 64'd0);
    check({tag, "_m"},    64'(m_out), 64'd0);
    check({tag, "_a"},    64'(a_out), 64'd0);
    check({tag, "_q"},    64'(q_out), 64'd0);
    check({tag, "_cnt"},  64'(shift_cnt), 64'd0);
  endtask

  // One normalization. glitch>0 pulses start (with different operands)
  // in that cycle number; it must be ignored.
  task automatic run_op(input logic [15:0] dv, input logic [15:0] dd, input int glitch);
    int          msb, k, lat, cyc;
    bit          seen;
    logic [16:0] m_exp;
    logic [32:0] aq_exp;
    // Reference model: shifts needed = distance of leading one from bit 15,
    // clamped to 7; zero divisor means no shift and a one-cycle result.
    msb = -1;
    for (int i = 0; i < 16; i++) if (dv[i]) msb = i;
    if (dv == 16'd0) begin
      k = 0; lat = 1;
    end else begin
      k = (15 - msb > 7) ? 7 : 15 - msb;
      lat = k + 2;
    end
    m_exp  = {1'b0, dv} << k;
    aq_exp = {17'd0, dd} << k;

    @(negedge clk);
    divisor_in = dv; dividend_in = dd; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    divisor_in = 16'h7777; dividend_in = 16'h3333;
    cyc = 1; seen = 0;
    while (cyc <= 40 && !seen) begin
      @(negedge clk);
      if (cyc == glitch) begin
        start = 1'b1; divisor_in = 16'h0001; dividend_in = 16'h5555;
      end
      if (done) begin
        seen = 1;
        check("latency", 64'(cyc), 64'(lat));
        check("busy_done", 64'(busy), 64'd1);
        check("dbz", 64'(div_by_zero), 64'(dv == 16'd0));
        check("m_out", 64'(m_out), 64'(m_exp));
        check("a_out", 64'(a_out), 64'(aq_exp[32:16]));
        check("q_out", 64'(q_out), 64'(aq_exp[15:0]));
        check("shift_cnt", 64'(shift_cnt), 64'(k));
      end
      @(posedge clk);
      #1 start = 1'b0;
      if (!seen) cyc++;
    end
    if (!seen) begin
      tests++; fails++;
      $error("FAIL done_timeout got=none exp=cycle %0d", lat);
    end
    if (glitch > 0) begin
      @(negedge clk);
      check("idle_after_glitch", 64'(busy), 64'd0);
      check("hold_cnt", 64'(shift_cnt), 64'(k));
    end
  endtask

  initial begin
    logic [15:0] rdv;
    // Reset
    #1;
    check_all_zero("reset");
    @(negedge clk); @(negedge clk);
    rst_b = 1'b1;

    // Directed cases
    run_op(16'h8000, 16'h1234, 0);
    run_op(16'h0100, 16'hF000, 0);
    run_op(16'h0001, 16'h0003, 0);
    run_op(16'h0000, 16'hABCD, 0);
    @(negedge clk);
    check("dbz_held", 64'(div_by_zero), 64'd1);
    check("done_low_idle", 64'(done), 64'd0);
    check("q_held", 64'(q_out), 64'hABCD);
    run_op(16'h4000, 16'h0F0F, 0);

    // start during SHIFT, then start during the DONE pulse
    run_op(16'h0100, 16'hF000, 3);
    run_op(16'h0100, 16'hF000, 9);
    // back-to-back: run_op issues start on the cycle right after done
    run_op(16'h0020, 16'h8001, 0);
    run_op(16'h0003, 16'hFFFF, 0);

    // Reset in the middle of SHIFT after three shifts
    @(negedge clk);
    divisor_in = 16'h0100; dividend_in = 16'hF000; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("pre_reset_cnt", 64'(shift_cnt), 64'd3);
    rst_b = 1'b0;
    #1;
    check_all_zero("mid_reset");
    @(negedge clk);
    rst_b = 1'b1;
    run_op(16'h0100, 16'hF000, 0);

    // Randomized operands with a spread of leading-one positions
    for (int n = 0; n < 40; n++) begin
      rdv = 16'($urandom_range(0, 65535) >> $urandom_range(0, 16));
      if ($urandom_range(0, 9) == 0) rdv = 16'd0;
      run_op(rdv, 16'($urandom_range(0, 65535)), 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
